spi_txn_sequencer: RTL and testbench

- Upstream command stage for the two-device SPI link top: buffers 32-bit words from a host stream and hands them to the link one transaction at a time.
- Launches each transfer, waits for the link's phase-2 completion, and captures the returned word.
- Checks that the returned word equals the sent word + 1, then emits a result record on a valid/ready stream.
- Timeout watchdog prevents a hung link from stalling the host.

---
 rtl/spi_seq_pkg.sv | 21 ++
 rtl/spi_seq_fifo.sv | 61 ++++++
 rtl/spi_txn_sequencer.sv | 139 +++++++++++++
 tb/tb_spi_txn_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and defaults for the SPI transaction sequencer.
package spi_seq_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 1024;
  localparam int ERR_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    EMIT   = 2'd3
  } seq_state_e;

  // Watchdog counts 0..TIMEOUT-1; keep at least one bit for tiny timeouts.
  function automatic int tmr_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous command FIFO; first-word data is always visible on rdata_o.
module spi_seq_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push_d;
  logic              pop_d;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_d  = push_i && !full_o;
  assign pop_d   = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (push_d) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_d) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_d) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_d && !pop_d) begin
        count_q <= count_q + 1'b1;
      end else if (pop_d && !push_d) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Buffers host words, runs one link transfer per word, checks resp == sent + 1.
// state  | meaning
// IDLE   | wait for a queued word, pop it into cur_word
// LAUNCH | one-cycle link_start pulse, clear watchdog
// WAIT   | wait for link_done or watchdog expiry
// EMIT   | hold result record until m_ready
module spi_txn_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int ERR_W   = ERR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [DATA_W-1:0] link_data,
  output logic              link_start,
  input  logic              link_done,
  input  logic [DATA_W-1:0] link_resp,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_ok,
  output logic              m_timeout,
  output logic [ERR_W-1:0]  err_count,
  output logic              busy
);

  localparam int TMR_W = tmr_width(TIMEOUT);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  seq_state_e        state_q;
  logic [DATA_W-1:0] cur_word_q;
  logic              link_start_q;
  logic [TMR_W-1:0]  timer_q;
  logic              m_valid_q;
  logic [DATA_W-1:0] m_data_q;
  logic              m_ok_q;
  logic              m_timeout_q;
  logic [ERR_W-1:0]  err_q;

  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop_d;
  logic [DATA_W-1:0] resp_exp_d;

  assign pop_d      = (state_q == IDLE) && !fifo_empty;
  assign resp_exp_d = cur_word_q + 1'b1;

  spi_seq_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (s_valid),
    .wdata_i (s_data),
    .pop_i   (pop_d),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_word_q   <= '0;
      link_start_q <= 1'b0;
      timer_q      <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_ok_q       <= 1'b0;
      m_timeout_q  <= 1'b0;
      err_q        <= '0;
    end else begin
      link_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            cur_word_q   <= fifo_rdata;
            link_start_q <= 1'b1;
            state_q      <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A completion in the final watchdog cycle still counts as a response.
          if (link_done) begin
            m_data_q    <= link_resp;
            m_ok_q      <= (link_resp == resp_exp_d);
            m_timeout_q <= 1'b0;
            m_valid_q   <= 1'b1;
            state_q     <= EMIT;
          end else if (timer_q == TMR_LAST) begin
            m_data_q    <= '0;
            m_ok_q      <= 1'b0;
            m_timeout_q <= 1'b1;
            m_valid_q   <= 1'b1;
            state_q     <= EMIT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        EMIT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            if (!m_ok_q && (err_q != '1)) begin
              err_q <= err_q + 1'b1;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready    = !fifo_full;
  assign link_data  = cur_word_q;
  assign link_start = link_start_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_ok       = m_ok_q;
  assign m_timeout  = m_timeout_q;
  assign err_count  = err_q;
  assign busy       = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer with a small delayed-response link model.
module tb_spi_txn_sequencer;

  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [DW-1:0] link_data;
  logic          link_start;
  logic          link_done = 1'b0;
  logic [DW-1:0] link_resp = '0;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_ok;
  logic          m_timeout;
  logic [15:0]   err_count;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic          rsp_en  = 1'b0;
  int            rsp_dly = 3;
  logic [DW-1:0] rsp_add = 32'd1;
  bit            pend    = 1'b0;
  int            rcnt    = 0;

  always #5 clk = ~clk;

  spi_txn_sequencer #(
    .DATA_W  (DW),
    .DEPTH   (4),
    .TIMEOUT (TMO),
    .ERR_W   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .link_data  (link_data),
    .link_start (link_start),
    .link_done  (link_done),
    .link_resp  (link_resp),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_ok       (m_ok),
    .m_timeout  (m_timeout),
    .err_count  (err_count),
    .busy       (busy)
  );

  // Link model: answers rsp_dly negedges after link_start with link_data + rsp_add.
  always @(negedge clk) begin
    link_done = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else if (link_start) begin
      pend = 1'b1;
      rcnt = 0;
    end else if (pend && rsp_en) begin
      rcnt++;
      if (rcnt >= rsp_dly) begin
        link_done = 1'b1;
        link_resp = link_data + rsp_add;
        pend      = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 50; i++) begin
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("push_bound", 32'd0, 32'd1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_start(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (link_start) begin
        cyc = i;
        break;
      end
    end
    if (cyc < 0) check("start_bound", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (m_valid) begin
        cyc = i;
        break;
      end
    end
    if (cyc < 0) check("valid_bound", 32'd0, 32'd1);
  endtask

  task automatic take_record();
    m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
  endtask

  logic [DW-1:0] w [6];

  initial begin
    #100000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int  c;
    int  idx;
    bit  acc;
    bit  seen;

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_link_start", link_start, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Basic transaction, response 3 cycles after start.
    rsp_en = 1'b1; rsp_dly = 3; rsp_add = 32'd1;
    push_word(32'h10);
    check("t1_busy", busy, 1);
    @(posedge clk); #1;
    check("t1_start_lat", link_start, 1);
    check("t1_link_data_l", link_data, 32'h10);
    @(posedge clk); #1;
    check("t1_start_pulse", link_start, 0);
    check("t1_link_data_w", link_data, 32'h10);
    wait_valid(20, c);
    check("t1_valid_lat", c, 3);
    check("t1_m_data", m_data, 32'h11);
    check("t1_m_ok", m_ok, 1);
    check("t1_m_timeout", m_timeout, 0);
    check("t1_link_data_e", link_data, 32'h10);
    take_record();
    check("t1_m_valid_clr", m_valid, 0);
    check("t1_err", err_count, 0);

    // Wrap-around: 0xFFFFFFFF + 1 = 0.
    push_word(32'hFFFF_FFFF);
    wait_valid(30, c);
    check("t2_m_data", m_data, 32'h0);
    check("t2_m_ok", m_ok, 1);
    take_record();
    check("t2_err", err_count, 0);

    // Bad response, back-pressured record.
    rsp_add = 32'd0;
    push_word(32'h5);
    wait_valid(30, c);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("t3_hold_valid", m_valid, 1);
      check("t3_hold_data", m_data, 32'h5);
      check("t3_hold_ok", m_ok, 0);
    end
    take_record();
    check("t3_err", err_count, 1);
    rsp_add = 32'd1;

    // Watchdog: no response, 8 WAIT cycles.
    rsp_en = 1'b0;
    push_word(32'h20);
    wait_start(10, c);
    wait_valid(20, c);
    check("t4_tmo_lat", c, 9);
    check("t4_m_timeout", m_timeout, 1);
    check("t4_m_data", m_data, 32'h0);
    check("t4_m_ok", m_ok, 0);
    take_record();
    check("t4_err", err_count, 2);

    // Response on the final WAIT cycle beats the watchdog.
    rsp_en = 1'b1; rsp_dly = 8;
    push_word(32'h30);
    wait_start(10, c);
    wait_valid(20, c);
    check("t5_lat", c, 9);
    check("t5_m_timeout", m_timeout, 0);
    check("t5_m_ok", m_ok, 1);
    check("t5_m_data", m_data, 32'h31);
    take_record();
    check("t5_err", err_count, 2);

    // Six words with a stalled link: five accepted, then backpressure.
    rsp_en = 1'b0; rsp_dly = 2;
    for (int k = 0; k < 6; k++) w[k] = 32'h100 + 32'h11 * k;
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = w[idx];
      acc     = s_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    s_valid = 1'b0;
    check("t6_accepted", idx, 5);
    check("t6_s_ready", s_ready, 0);
    check("t6_busy", busy, 1);
    rsp_en = 1'b1;
    fork
      push_word(w[5]);
      begin
        for (int k = 0; k < 6; k++) begin
          wait_valid(40, c);
          check("t6_m_data", m_data, w[k] + 32'd1);
          check("t6_m_ok", m_ok, 1);
          take_record();
        end
      end
    join
    check("t6_err", err_count, 2);

    // Reset during WAIT abandons the transfer.
    rsp_en = 1'b0;
    push_word(32'h50);
    wait_start(10, c);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t7_s_ready", s_ready, 1);
    check("t7_link_data", link_data, 32'h0);
    check("t7_link_start", link_start, 0);
    check("t7_m_valid", m_valid, 0);
    check("t7_m_data", m_data, 32'h0);
    check("t7_m_ok", m_ok, 0);
    check("t7_m_timeout", m_timeout, 0);
    check("t7_err", err_count, 0);
    check("t7_busy", busy, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (m_valid || link_start) seen = 1'b1;
    end
    check("t7_no_record", seen, 0);
    rsp_en = 1'b1; rsp_dly = 3;
    push_word(32'h60);
    wait_valid(30, c);
    check("t7_post_data", m_data, 32'h61);
    check("t7_post_ok", m_ok, 1);
    take_record();
    check("t7_post_err", err_count, 0);
    check("t7_post_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
